multicycle_control: RTL and testbench

- Main control FSM for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory, writeback and PC-update states, and drives the 4-bit estado bus consumed by the ALU and the other datapath blocks.
- Decodes the latched instruction into ALU controls (alusrc, alucontrol, branch, negativo) and a sign-magnitude immediate.
- Handshakes with instruction/data memory through mem_ready.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control FSM and its datapath/memory side.
// mem_ready is a completion strobe: the request (memread/memwrite/fetch) stays
// asserted every cycle of its state, and the access completes on the first
// rising edge at which mem_ready is high; mem_ready is ignored in all other states.
interface multicycle_control_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        pcsrc;
  logic [3:0]  estado;
  logic        alusrc;
  logic [3:0]  alucontrol;
  logic        branch;
  logic        negativo;
  logic [31:0] immediate;
  logic        memread;
  logic        memwrite;
  logic        irwrite;
  logic        regwrite;
  logic        memtoreg;
  logic        pcwrite;
  logic        pc_sel;
  logic        illegal;
  logic [31:0] instr_count;

  modport master (
    output instruction, mem_ready, pcsrc,
    input  estado, alusrc, alucontrol, branch, negativo, immediate,
           memread, memwrite, irwrite, regwrite, memtoreg, pcwrite,
           pc_sel, illegal, instr_count
  );

  modport slave (
    input  instruction, mem_ready, pcsrc,
    output estado, alusrc, alucontrol, branch, negativo, immediate,
           memread, memwrite, irwrite, regwrite, memtoreg, pcwrite,
           pc_sel, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath: sequences the instruction
// phases, decodes the latched instruction and drives the memory/register strobes.
module multicycle_control #(
  parameter int EXEC_BR_CYCLES = 2,
  parameter int IDLE_CYCLES    = 1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_FETCH   = 4'b0001,
    S_DECODE  = 4'b0010,
    S_MEM_RD  = 4'b0011,
    S_MEM_WR  = 4'b0100,
    S_EXEC    = 4'b0101,
    S_EXEC_BR = 4'b0110,
    S_WB      = 4'b0111,
    S_PCUPD   = 4'b1000,
    S_ERROR   = 4'b1111
  } state_e;

  typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_BR} kind_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counter terminal values; a parameter of 0 behaves like 1.
  localparam logic [7:0] IDLE_LAST = (IDLE_CYCLES > 1) ? 8'(IDLE_CYCLES - 1) : 8'd0;
  localparam logic [7:0] BR_LAST   = (EXEC_BR_CYCLES > 1) ? 8'(EXEC_BR_CYCLES - 1) : 8'd0;

  state_e      state_q;
  kind_e       kind_q;
  logic [7:0]  cnt_q;
  logic [4:0]  rd_q;
  logic        alusrc_q, branch_q, neg_q, memtoreg_q, illegal_q;
  logic [3:0]  aluctl_q;
  logic [31:0] imm_q, count_q;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        unused_rs1;

  assign instr      = bus.instruction;
  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign unused_rs1 = ^instr[19:15];

  logic        alusrc_d, branch_d, legal_d, neg_d;
  logic [3:0]  aluctl_d;
  logic [31:0] imm_sext_d, imm_mag_d;
  kind_e       kind_d;

  always_comb begin
    alusrc_d   = 1'b0;
    aluctl_d   = 4'b0000;
    branch_d   = 1'b0;
    kind_d     = K_ALU;
    legal_d    = 1'b0;
    imm_sext_d = '0;
    case (opcode)
      OP_R: begin
        legal_d = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000)      aluctl_d = 4'b0010;
            else if (funct7 == 7'b0100000) aluctl_d = 4'b0110;
            else                           legal_d  = 1'b0;
          end
          3'b111:  aluctl_d = 4'b0000;
          3'b110:  aluctl_d = 4'b0001;
          3'b100:  aluctl_d = 4'b0100;
          3'b101: begin
            if (funct7 == 7'b0000000) aluctl_d = 4'b0101;
            else                      legal_d  = 1'b0;
          end
          default: legal_d = 1'b0;
        endcase
      end
      OP_IMM: if (funct3 == 3'b000) begin
        legal_d    = 1'b1;
        alusrc_d   = 1'b1;
        aluctl_d   = 4'b0011;
        imm_sext_d = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        legal_d    = 1'b1;
        alusrc_d   = 1'b1;
        aluctl_d   = 4'b0010;
        kind_d     = K_LW;
        imm_sext_d = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: if (funct3 == 3'b010) begin
        legal_d    = 1'b1;
        alusrc_d   = 1'b1;
        aluctl_d   = 4'b0010;
        kind_d     = K_SW;
        imm_sext_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
        legal_d    = 1'b1;
        alusrc_d   = 1'b1;
        branch_d   = 1'b1;
        aluctl_d   = funct3[0] ? 4'b1111 : 4'b0110;
        kind_d     = K_BR;
        imm_sext_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: ;
    endcase
    // The datapath consumes a sign-magnitude immediate.
    neg_d     = imm_sext_d[31];
    imm_mag_d = neg_d ? (~imm_sext_d + 32'd1) : imm_sext_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_ALU;
      cnt_q      <= '0;
      rd_q       <= '0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= '0;
      branch_q   <= 1'b0;
      neg_q      <= 1'b0;
      imm_q      <= '0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_q >= IDLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_FETCH: if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (!legal_d) begin
            illegal_q <= 1'b1;
            state_q   <= S_ERROR;
          end else begin
            alusrc_q <= alusrc_d;
            aluctl_q <= aluctl_d;
            branch_q <= branch_d;
            neg_q    <= neg_d;
            imm_q    <= imm_mag_d;
            kind_q   <= kind_d;
            rd_q     <= instr[11:7];
            cnt_q    <= '0;
            state_q  <= (kind_d == K_BR) ? S_EXEC_BR : S_EXEC;
          end
        end
        S_EXEC: begin
          case (kind_q)
            K_LW:    state_q <= S_MEM_RD;
            K_SW:    state_q <= S_MEM_WR;
            default: state_q <= S_WB;
          endcase
        end
        S_EXEC_BR: begin
          if (cnt_q >= BR_LAST) begin
            cnt_q   <= '0;
            state_q <= S_PCUPD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_MEM_RD: if (bus.mem_ready) begin
          memtoreg_q <= 1'b1;
          state_q    <= S_WB;
        end
        S_MEM_WR: if (bus.mem_ready) state_q <= S_PCUPD;
        S_WB:     state_q <= S_PCUPD;
        S_PCUPD: begin
          memtoreg_q <= 1'b0;
          count_q    <= count_q + 32'd1;
          state_q    <= S_FETCH;
        end
        S_ERROR:  state_q <= S_ERROR;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes follow the current state (and mem_ready) without a register stage.
  assign bus.memread  = (state_q == S_FETCH) || (state_q == S_MEM_RD);
  assign bus.irwrite  = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.memwrite = (state_q == S_MEM_WR);
  assign bus.regwrite = (state_q == S_WB) && (rd_q != 5'd0);
  assign bus.pcwrite  = (state_q == S_PCUPD);
  assign bus.pc_sel   = (state_q == S_PCUPD) && branch_q && bus.pcsrc;

  assign bus.estado      = state_q;
  assign bus.alusrc      = alusrc_q;
  assign bus.alucontrol  = aluctl_q;
  assign bus.branch      = branch_q;
  assign bus.negativo    = neg_q;
  assign bus.immediate   = imm_q;
  assign bus.memtoreg    = memtoreg_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand sequences for reset
// corner cases, and randomized instructions against an instruction-level model.
module tb_multicycle_control;

  localparam int BR_CYC   = 2;
  localparam int IDLE_CYC = 1;
  localparam int W        = 11;

  localparam logic [3:0] ST_IDLE = 4'b0000, ST_FETCH = 4'b0001, ST_DECODE = 4'b0010,
                         ST_EXEC = 4'b0101, ST_EXEC_BR = 4'b0110, ST_MEM_RD = 4'b0011,
                         ST_MEM_WR = 4'b0100, ST_WB = 4'b0111, ST_PCUPD = 4'b1000,
                         ST_ERROR = 4'b1111;

  localparam logic [W-1:0] ALL   = '1;
  localparam logic [W-1:0] NO_MT = {{(W-1){1'b1}}, 1'b0};

  localparam int C_ILL = 0, C_ALU = 1, C_LW = 2, C_SW = 3, C_BR = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  multicycle_control_if bus();

  multicycle_control #(.EXEC_BR_CYCLES(BR_CYC), .IDLE_CYCLES(IDLE_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic         mr_q[$];
  logic         ps_q[$];

  typedef struct {
    int          cls;
    logic        alusrc;
    logic [3:0]  alu;
    logic        br;
    logic        neg;
    logic [31:0] mag;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    int          fw;
    int          mw;
    logic        pcs;
    logic        ill;
    logic        alusrc;
    logic [3:0]  alu;
    logic        br;
    logic        neg;
    logic [31:0] imm;
  } vec_t;

  function automatic logic [W-1:0] mk(input logic [3:0] est, input logic rd, input logic wr,
                                      input logic ir, input logic rw, input logic pw,
                                      input logic ps, input logic mt);
    return {est, rd, wr, ir, rw, pw, ps, mt};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.estado, bus.memread, bus.memwrite, bus.irwrite, bus.regwrite,
            bus.pcwrite, bus.pc_sel, bus.memtoreg};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level reference: what the instruction means, not how it is decoded.
  function automatic dec_t model_decode(input logic [31:0] w);
    dec_t        d;
    int          imm;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    d.cls = C_ILL; d.alusrc = 1'b0; d.alu = 4'b0000; d.br = 1'b0; d.neg = 1'b0; d.mag = '0;
    imm = 0;
    if (op == 7'h33) begin
      d.cls = C_ALU;
      if (f3 == 3'b000 && f7 == 7'h00)      d.alu = 4'b0010;
      else if (f3 == 3'b000 && f7 == 7'h20) d.alu = 4'b0110;
      else if (f3 == 3'b111)                d.alu = 4'b0000;
      else if (f3 == 3'b110)                d.alu = 4'b0001;
      else if (f3 == 3'b100)                d.alu = 4'b0100;
      else if (f3 == 3'b101 && f7 == 7'h00) d.alu = 4'b0101;
      else                                  d.cls = C_ILL;
    end else if ((op == 7'h13 && f3 == 3'b000) || (op == 7'h03 && f3 == 3'b010)) begin
      d.cls = (op == 7'h13) ? C_ALU : C_LW;
      d.alusrc = 1'b1;
      d.alu = (op == 7'h13) ? 4'b0011 : 4'b0010;
      s12 = w[31:20];
      imm = int'($signed(s12));
    end else if (op == 7'h23 && f3 == 3'b010) begin
      d.cls = C_SW; d.alusrc = 1'b1; d.alu = 4'b0010;
      s12 = {w[31:25], w[11:7]};
      imm = int'($signed(s12));
    end else if (op == 7'h63 && (f3 == 3'b000 || f3 == 3'b001)) begin
      d.cls = C_BR; d.alusrc = 1'b1; d.br = 1'b1;
      d.alu = (f3 == 3'b000) ? 4'b0110 : 4'b1111;
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      imm = int'($signed(b13));
    end
    d.neg = (imm < 0);
    d.mag = (imm < 0) ? -imm : imm;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input logic mr, input logic ps);
    exp_q.push_back(e);
    msk_q.push_back(m);
    mr_q.push_back(mr);
    ps_q.push_back(ps);
  endtask

  // One clock: inputs are applied just after the rising edge, outputs checked on the falling edge.
  task automatic step(input logic mr, input logic ps, input logic [W-1:0] e,
                      input logic [W-1:0] m, input string tag);
    logic [W-1:0] obs;
    bus.mem_ready = mr;
    bus.pcsrc     = ps;
    @(negedge clk);
    obs = observe();
    n_cmp++;
    if ((obs & m) !== (e & m)) begin
      n_bad++;
      $display("FAIL %s cycle {estado,rd,wr,ir,rw,pw,pcsel,mtr}: got %b, expected %b", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0)
      step(mr_q.pop_front(), ps_q.pop_front(), exp_q.pop_front(), msk_q.pop_front(), tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.mem_ready = rnd_bit();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_strobes"}, 32'(observe()), 32'(mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0)));
    chk({tag, "_count"}, bus.instr_count, 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, "_dec"}, {25'd0, bus.alusrc, bus.alucontrol, bus.branch, bus.negativo}, 32'd0);
    chk({tag, "_imm"}, bus.immediate, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < IDLE_CYC; i++) push(mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
    drain({tag, "_idle"});
  endtask

  // Runs one instruction from FETCH; builds the expected cycle trace from the instruction's meaning.
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic pcs,
                           input string tag);
    dec_t d;
    logic rw;
    d  = model_decode(w);
    rw = (w[11:7] != 5'd0);
    bus.instruction = w;
    for (int i = 0; i < fw; i++) push(mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0), ALL, 1'b0, rnd_bit());
    push(mk(ST_FETCH, 1, 0, 1, 0, 0, 0, 0), ALL, 1'b1, rnd_bit());
    push(mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
    if (d.cls == C_ILL) begin
      for (int i = 0; i < 10; i++) push(mk(ST_ERROR, 0, 0, 0, 0, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
    end else if (d.cls == C_BR) begin
      for (int i = 0; i < BR_CYC; i++) push(mk(ST_EXEC_BR, 0, 0, 0, 0, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
      push(mk(ST_PCUPD, 0, 0, 0, 0, 1, pcs, 0), ALL, rnd_bit(), pcs);
    end else begin
      push(mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
      if (d.cls == C_LW) begin
        for (int i = 0; i < mw; i++) push(mk(ST_MEM_RD, 1, 0, 0, 0, 0, 0, 0), ALL, 1'b0, rnd_bit());
        push(mk(ST_MEM_RD, 1, 0, 0, 0, 0, 0, 0), NO_MT, 1'b1, rnd_bit());
        push(mk(ST_WB, 0, 0, 0, rw, 0, 0, 1), ALL, rnd_bit(), rnd_bit());
        push(mk(ST_PCUPD, 0, 0, 0, 0, 1, 0, 0), NO_MT, rnd_bit(), rnd_bit());
      end else if (d.cls == C_SW) begin
        for (int i = 0; i < mw; i++) push(mk(ST_MEM_WR, 0, 1, 0, 0, 0, 0, 0), ALL, 1'b0, rnd_bit());
        push(mk(ST_MEM_WR, 0, 1, 0, 0, 0, 0, 0), ALL, 1'b1, rnd_bit());
        push(mk(ST_PCUPD, 0, 0, 0, 0, 1, 0, 0), ALL, rnd_bit(), rnd_bit());
      end else begin
        push(mk(ST_WB, 0, 0, 0, rw, 0, 0, 0), ALL, rnd_bit(), rnd_bit());
        push(mk(ST_PCUPD, 0, 0, 0, 0, 1, 0, 0), ALL, rnd_bit(), rnd_bit());
      end
    end
    drain(tag);
    if (d.cls == C_ILL) begin
      chk({tag, "_illegal"}, 32'(bus.illegal), 32'd1);
      do_reset({tag, "_reset"});
    end else begin
      model_cnt++;
      chk({tag, "_count"}, bus.instr_count, 32'(model_cnt));
      chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
      chk({tag, "_dec"}, {25'd0, bus.alusrc, bus.alucontrol, bus.branch, bus.negativo},
          {25'd0, d.alusrc, d.alu, d.br, d.neg});
      chk({tag, "_imm"}, bus.immediate, d.mag);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0:  begin w[6:0] = 7'h33; w[14:12] = 3'b000; w[31:25] = 7'h00; end
      1:  begin w[6:0] = 7'h33; w[14:12] = 3'b000; w[31:25] = 7'h20; end
      2:  begin w[6:0] = 7'h33; w[14:12] = 3'b111; end
      3:  begin w[6:0] = 7'h33; w[14:12] = 3'b110; end
      4:  begin w[6:0] = 7'h33; w[14:12] = 3'b100; end
      5:  begin w[6:0] = 7'h33; w[14:12] = 3'b101; w[31:25] = 7'h00; end
      6:  begin w[6:0] = 7'h13; w[14:12] = 3'b000; end
      7:  begin w[6:0] = 7'h03; w[14:12] = 3'b010; end
      8:  begin w[6:0] = 7'h23; w[14:12] = 3'b010; end
      9:  begin w[6:0] = 7'h63; w[14:12] = {2'b00, w[12]}; end
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  vec_t vecs[14];

  initial begin
    reset = 1'b1;
    bus.instruction = '0;
    bus.mem_ready = 1'b0;
    bus.pcsrc = 1'b0;

    //          instr         fw mw pcs  ill src alu     br neg imm
    vecs[0]  = '{32'h002081B3, 0, 0, 1'b0, 0, 0, 4'b0010, 0, 0, 32'd0};
    vecs[1]  = '{32'hFFB00093, 1, 0, 1'b0, 0, 1, 4'b0011, 0, 1, 32'd5};
    vecs[2]  = '{32'h0080A283, 0, 3, 1'b0, 0, 1, 4'b0010, 0, 0, 32'd8};
    vecs[3]  = '{32'h00208463, 0, 0, 1'b1, 0, 1, 4'b0110, 1, 0, 32'd8};
    vecs[4]  = '{32'hFE2098E3, 0, 0, 1'b0, 0, 1, 4'b1111, 1, 1, 32'd16};
    vecs[5]  = '{32'hFE20AE23, 2, 2, 1'b0, 0, 1, 4'b0010, 0, 1, 32'd4};
    vecs[6]  = '{32'h40208233, 0, 0, 1'b0, 0, 0, 4'b0110, 0, 0, 32'd0};
    vecs[7]  = '{32'h0020F2B3, 4, 0, 1'b0, 0, 0, 4'b0000, 0, 0, 32'd0};
    vecs[8]  = '{32'h0020E033, 0, 0, 1'b0, 0, 0, 4'b0001, 0, 0, 32'd0};
    vecs[9]  = '{32'h0020C333, 0, 0, 1'b0, 0, 0, 4'b0100, 0, 0, 32'd0};
    vecs[10] = '{32'h0020D3B3, 0, 0, 1'b0, 0, 0, 4'b0101, 0, 0, 32'd0};
    vecs[11] = '{32'h80000093, 0, 0, 1'b0, 0, 1, 4'b0011, 0, 1, 32'h800};
    vecs[12] = '{32'hFE2098E3, 0, 0, 1'b1, 0, 1, 4'b1111, 1, 1, 32'd16};
    vecs[13] = '{32'h0000007F, 0, 0, 1'b0, 1, 0, 4'b0000, 0, 0, 32'd0};

    #1;
    do_reset("por");

    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].instr, vecs[i].fw, vecs[i].mw, vecs[i].pcs, $sformatf("vec%0d", i));
      if (!vecs[i].ill) begin
        chk($sformatf("vec%0d_tbl_dec", i),
            {25'd0, bus.alusrc, bus.alucontrol, bus.branch, bus.negativo},
            {25'd0, vecs[i].alusrc, vecs[i].alu, vecs[i].br, vecs[i].neg});
        chk($sformatf("vec%0d_tbl_imm", i), bus.immediate, vecs[i].imm);
      end
    end

    // Reset while a store is stalled in the memory phase, after some instructions retired.
    run_instr(32'h002081B3, 0, 0, 1'b0, "pre_memwr");
    bus.instruction = 32'hFE20AE23;
    step(1'b1, 1'b0, mk(ST_FETCH, 1, 0, 1, 0, 0, 0, 0), ALL, "memwr_fetch");
    step(1'b0, 1'b0, mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0), ALL, "memwr_decode");
    step(1'b1, 1'b0, mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0), ALL, "memwr_exec");
    step(1'b0, 1'b0, mk(ST_MEM_WR, 0, 1, 0, 0, 0, 0, 0), ALL, "memwr_wait0");
    step(1'b0, 1'b0, mk(ST_MEM_WR, 0, 1, 0, 0, 0, 0, 0), ALL, "memwr_wait1");
    do_reset("memwr_reset");

    for (int i = 0; i < 40; i++)
      run_instr(gen_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit(),
                $sformatf("rand%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
